draw_cmd_queue: RTL and testbench
=================================

// Module: draw_cmd_queue
// PURPOSE
//  Command FIFO upstream of the draw unit. Buffers draw commands written by the CPU/bus side and
//  issues them one at a time over the draw unit's command/data/commit/ack/done handshake.
//  Discards opcodes the draw unit cannot execute (which would otherwise hang it forever).
// PARAMETERS
//  DEPTH      8     number of queue entries; power of two, >= 2
//  AW         3     log2(DEPTH); pointer width; count is AW+1 bits
//  CMD_RECT   8'h01 only opcode forwarded downstream
// PORTS
//  clk        in   1    system clock
//  rst_n      in   1    synchronous active-low reset
//  push       in   1    enqueue {push_cmd, push_data} this cycle
//  push_cmd   in   8    draw opcode
//  push_data  in   256  draw payload; RECT: [9:0]x [19:10]y [29:20]w [39:30]h [55:40]rgb565
//  flush      in   1    discard all queued (not yet issued) entries
//  full       out  1    count == DEPTH
//  empty      out  1    count == 0
//  count      out  AW+1 entries queued (not including the one in flight)
//  overflow   out  1    sticky: a push was dropped because the queue was full
//  bad_cmd    out  1    sticky: an unsupported opcode was discarded
//  command    out  8    opcode to draw unit (registered)
//  data       out  256  payload to draw unit (registered)
//  commit     out  1    request to draw unit; held until ack
//  ack        in   1    draw unit accepted command (1-cycle pulse)
//  done       in   1    draw unit finished current command
//  busy       out  1    state != S_IDLE or !empty
// BEHAVIOUR
//  Reset (sync, rst_n==0 at posedge): state=S_IDLE, pointers/count=0, commit=0, command=0, data=0,
//   overflow=0, bad_cmd=0. Reset mid-operation abandons any in-flight command; draw unit shares rst_n.
//  Storage: circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH; count tracks occupancy.
//  Push: accepted iff !full at the clock edge. Push while full is dropped and sets overflow, even if
//   a pop happens the same cycle. Push and pop in the same cycle: count unchanged.
//  FSM:
//   S_IDLE: if !empty and head.cmd==CMD_RECT: load command/data from head, pop, commit<=1,
//           -> S_ISSUE. If !empty and head.cmd!=CMD_RECT: pop, bad_cmd<=1, stay S_IDLE (1 entry/cycle).
//           If empty: stay.
//   S_ISSUE: commit=1, command/data stable. On ack==1: commit<=0, -> S_WAIT.
//   S_WAIT: commit=0. On done==1: -> S_IDLE. Next issue earliest 1 cycle after done.
//  Issue latency: head valid in S_IDLE -> commit high next cycle; draw unit captures on that edge,
//   ack arrives 1 cycle later, so commit is high for exactly 2 cycles when the unit is idle.
//  command/data hold their last value after issue (not cleared) until the next load.
//  flush: clears pointers/count the same edge; the in-flight command (S_ISSUE/S_WAIT) is unaffected.
//   flush with simultaneous push: flush wins, push dropped, overflow not set. flush does not clear
//   sticky flags; only reset clears them.
//  ack outside S_ISSUE and done outside S_WAIT are ignored.
//  No combinational path from ack/done to commit/command/data.
// TESTING
//  1. Reset, push RECT{x=10,y=20,w=4,h=2,rgb=16'hF800}: commit rises 1 cycle after push edge,
//     command=8'h01, data[55:40]=16'hF800; ack pulse -> commit=0; done -> busy=0, empty=1.
//  2. Push 3 RECTs back-to-back with done delayed 50 cycles each: issued in FIFO order, never
//     overlapping, count goes 3->2->1->0 on each S_IDLE->S_ISSUE edge.
//  3. Fill DEPTH=8 entries with draw unit stalled, push 9th: full=1, overflow=1, count=8, 9th never issued.
//  4. Push opcodes 8'h07, 8'h01: 8'h07 discarded (bad_cmd=1, no commit), 8'h01 issued next.
//  5. 4 queued + 1 in S_WAIT, assert flush: count=0, empty=1, in-flight done still returns to S_IDLE,
//     no further commit.
//  6. Reset asserted in S_ISSUE: next edge commit=0, count=0, overflow=0, bad_cmd=0, state S_IDLE.

Source files
------------

// File: rtl/draw_cmd_queue.sv
// Command queue in front of the draw unit.
// Buffers CPU-side draw commands in a circular buffer and hands them to the
// draw unit one at a time. Opcodes the draw unit cannot execute are dropped,
// because issuing one would hang the unit forever.
//
// Handshake: while commit is high, command/data are stable and valid. The draw
// unit accepts with a 1-cycle ack pulse, and then (perhaps much later) signals
// completion with done. A new command is loaded no earlier than one cycle after
// done. commit, command and data come straight from registers, so ack and done
// have no combinational path to them.
module draw_cmd_queue #(
    parameter int          DEPTH    = 8,
    parameter int          AW       = 3,
    parameter logic [7:0]  CMD_RECT = 8'h01
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [7:0]     push_cmd,
    input  logic [255:0]   push_data,
    input  logic           flush,
    output logic           full,
    output logic           empty,
    output logic [AW:0]    count,
    output logic           overflow,
    output logic           bad_cmd,
    output logic [7:0]     command,
    output logic [255:0]   data,
    output logic           commit,
    input  logic           ack,
    input  logic           done,
    output logic           busy,
    output logic [1:0]     dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           commit_q, commit_d;
    logic [7:0]     command_q, command_d;
    logic [255:0]   data_q, data_d;
    logic           overflow_q, overflow_d;
    logic           bad_cmd_q, bad_cmd_d;

    logic [7:0]     mem_cmd  [DEPTH];
    logic [255:0]   mem_data [DEPTH];

    logic           full_w, empty_w;
    logic           push_ok;
    logic           pop;
    logic [7:0]     head_cmd;
    logic [255:0]   head_data;

    assign full_w    = (count_q == CNT_FULL);
    assign empty_w   = (count_q == '0);
    // flush wins over a simultaneous push; a push into a full queue is dropped
    assign push_ok   = push && !full_w && !flush;
    assign head_cmd  = mem_cmd[rd_ptr_q];
    assign head_data = mem_data[rd_ptr_q];

    // Issue FSM: pops the head when idle, forwarding RECT and discarding anything else
    always_comb begin
        state_d   = state_q;
        commit_d  = commit_q;
        command_d = command_q;
        data_d    = data_q;
        bad_cmd_d = bad_cmd_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A flush in the same cycle discards the head as well
                if (!empty_w && !flush) begin
                    pop = 1'b1;
                    if (head_cmd == CMD_RECT) begin
                        command_d = head_cmd;
                        data_d    = head_data;
                        commit_d  = 1'b1;
                        state_d   = S_ISSUE;
                    end else begin
                        bad_cmd_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (ack) begin
                    commit_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                commit_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Pointer, occupancy and overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push && full_w && !flush);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            commit_q   <= 1'b0;
            command_q  <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            bad_cmd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            commit_q   <= commit_d;
            command_q  <= command_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            bad_cmd_q  <= bad_cmd_d;
        end
    end

    // Queue storage; contents are only meaningful between rd_ptr and wr_ptr
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_cmd[wr_ptr_q]  <= push_cmd;
            mem_data[wr_ptr_q] <= push_data;
        end
    end

    assign full        = full_w;
    assign empty       = empty_w;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign bad_cmd     = bad_cmd_q;
    assign command     = command_q;
    assign data        = data_q;
    assign commit      = commit_q;
    assign busy        = (state_q != S_IDLE) || !empty_w;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_draw_cmd_queue.sv
// Directed bench for draw_cmd_queue: a behavioural draw unit is driven from
// tasks, and expected payloads are kept in an in-order queue.
module tb_draw_cmd_queue;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         push;
    logic [7:0]   push_cmd;
    logic [255:0] push_data;
    logic         flush;
    logic         full, empty;
    logic [3:0]   count;
    logic         overflow, bad_cmd;
    logic [7:0]   command;
    logic [255:0] data;
    logic         commit;
    logic         ack, done;
    logic         busy;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    logic [255:0] exp_q[$];

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    draw_cmd_queue #(.DEPTH(8), .AW(3), .CMD_RECT(8'h01)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd),
        .push_data(push_data), .flush(flush), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .bad_cmd(bad_cmd),
        .command(command), .data(data), .commit(commit), .ack(ack),
        .done(done), .busy(busy), .dbg_state_o(dbg_state)
    );

    function automatic logic [255:0] rect(input logic [9:0] x, input logic [9:0] y,
                                          input logic [9:0] w, input logic [9:0] h,
                                          input logic [15:0] rgb);
        logic [255:0] d;
        d = '0;
        d[9:0]   = x;
        d[19:10] = y;
        d[29:20] = w;
        d[39:30] = h;
        d[55:40] = rgb;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] c, input logic [255:0] d);
        push = 1'b1; push_cmd = c; push_data = d;
        step();
        push = 1'b0;
    endtask

    // draw unit: wait for commit, check the issued command, ack one cycle later,
    // and optionally report done after dly cycles
    task automatic serve(input string tag, input logic [3:0] exp_cnt, input int dly, input bit finish);
        int n;
        logic [255:0] exp_d;
        n = 0;
        while (!commit && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("%s commit_rise", tag), 256'(commit), 256'(1'b1));
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk($sformatf("%s command", tag), 256'(command), 256'(8'h01));
        chk($sformatf("%s data", tag), data, exp_d);
        chk($sformatf("%s count_at_issue", tag), 256'(count), 256'(exp_cnt));
        chk($sformatf("%s state_issue", tag), 256'(dbg_state), 256'(ST_ISSUE));
        step();
        chk($sformatf("%s commit_hold", tag), 256'(commit), 256'(1'b1));
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk($sformatf("%s commit_drop", tag), 256'(commit), 256'(1'b0));
        chk($sformatf("%s state_wait", tag), 256'(dbg_state), 256'(ST_WAIT));
        chk($sformatf("%s data_held", tag), data, exp_d);
        if (finish) begin
            repeat (dly) step();
            chk($sformatf("%s still_wait", tag), 256'(dbg_state), 256'(ST_WAIT));
            done = 1'b1;
            step();
            done = 1'b0;
            chk($sformatf("%s back_idle", tag), 256'(dbg_state), 256'(ST_IDLE));
        end
    endtask

    // count any commit seen over n cycles
    task automatic watch_no_commit(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (commit) seen++;
        end
        chk(tag, 256'(seen), 256'(0));
    endtask

    initial begin
        logic [255:0] d;
        rst_n = 1'b0; push = 1'b0; push_cmd = '0; push_data = '0;
        flush = 1'b0; ack = 1'b0; done = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // reset state
        chk("rst commit", 256'(commit), 256'(1'b0));
        chk("rst count", 256'(count), 256'(0));
        chk("rst empty", 256'(empty), 256'(1'b1));
        chk("rst full", 256'(full), 256'(1'b0));
        chk("rst overflow", 256'(overflow), 256'(1'b0));
        chk("rst bad_cmd", 256'(bad_cmd), 256'(1'b0));
        chk("rst command", 256'(command), 256'(0));
        chk("rst data", data, 256'(0));
        chk("rst busy", 256'(busy), 256'(1'b0));
        chk("rst state", 256'(dbg_state), 256'(ST_IDLE));

        // 1: single RECT, commit one cycle after the push edge
        d = rect(10'd10, 10'd20, 10'd4, 10'd2, 16'hF800);
        do_push(8'h01, d);
        exp_q.push_back(d);
        chk("t1 count_after_push", 256'(count), 256'(1));
        chk("t1 commit_low", 256'(commit), 256'(1'b0));
        chk("t1 busy", 256'(busy), 256'(1'b1));
        step();
        chk("t1 commit_next", 256'(commit), 256'(1'b1));
        chk("t1 rgb", 256'(data[55:40]), 256'(16'hF800));
        chk("t1 x", 256'(data[9:0]), 256'(10'd10));
        serve("t1", 4'd0, 3, 1'b1);
        chk("t1 busy_end", 256'(busy), 256'(1'b0));
        chk("t1 empty_end", 256'(empty), 256'(1'b1));

        // 2: warm-up in flight, three queued, done delayed 50 cycles each
        d = rect(10'd1, 10'd1, 10'd1, 10'd1, 16'h0001);
        do_push(8'h01, d);
        exp_q.push_back(d);
        serve("t2a", 4'd0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = rect(10'(100 + i), 10'(200 + i), 10'd8, 10'd8, 16'(16'h07E0 + i));
            do_push(8'h01, d);
            exp_q.push_back(d);
        end
        chk("t2 count3", 256'(count), 256'(3));
        chk("t2 commit_idle_wait", 256'(commit), 256'(1'b0));
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t2 count3_after_done", 256'(count), 256'(3));
        serve("t2b", 4'd2, 50, 1'b1);
        serve("t2c", 4'd1, 50, 1'b1);
        serve("t2d", 4'd0, 50, 1'b1);
        chk("t2 empty", 256'(empty), 256'(1'b1));

        // 3: stall the draw unit, fill all 8 entries, 9th dropped
        d = rect(10'd5, 10'd5, 10'd5, 10'd5, 16'h1234);
        do_push(8'h01, d);
        exp_q.push_back(d);
        serve("t3a", 4'd0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            d = rect(10'(300 + i), 10'(i), 10'd3, 10'd3, 16'(16'hA000 + i));
            do_push(8'h01, d);
            exp_q.push_back(d);
        end
        chk("t3 full", 256'(full), 256'(1'b1));
        chk("t3 count8", 256'(count), 256'(8));
        chk("t3 overflow_before", 256'(overflow), 256'(1'b0));
        do_push(8'h01, rect(10'd999, 10'd999, 10'd9, 10'd9, 16'hDEAD));
        chk("t3 overflow", 256'(overflow), 256'(1'b1));
        chk("t3 count_still8", 256'(count), 256'(8));
        chk("t3 full_still", 256'(full), 256'(1'b1));
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            serve($sformatf("t3_%0d", i), 4'(7 - i), 2, 1'b1);
        end
        watch_no_commit("t3 ninth_not_issued", 10);
        chk("t3 empty", 256'(empty), 256'(1'b1));

        // 4: unsupported opcode discarded, following RECT issued
        chk("t4 bad_before", 256'(bad_cmd), 256'(1'b0));
        do_push(8'h07, rect(10'd7, 10'd7, 10'd7, 10'd7, 16'h7777));
        chk("t4 count1", 256'(count), 256'(1));
        d = rect(10'd40, 10'd50, 10'd6, 10'd6, 16'h001F);
        do_push(8'h01, d);
        exp_q.push_back(d);
        chk("t4 bad_cmd", 256'(bad_cmd), 256'(1'b1));
        chk("t4 no_commit", 256'(commit), 256'(1'b0));
        chk("t4 count_after_discard", 256'(count), 256'(1));
        serve("t4", 4'd0, 2, 1'b1);

        // 5: flush with 4 queued and one in S_WAIT (push in the flush cycle is dropped)
        d = rect(10'd60, 10'd60, 10'd2, 10'd2, 16'hFFFF);
        do_push(8'h01, d);
        exp_q.push_back(d);
        serve("t5", 4'd0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_push(8'h01, rect(10'(500 + i), 10'd0, 10'd1, 10'd1, 16'h5555));
        end
        chk("t5 count4", 256'(count), 256'(4));
        flush = 1'b1; push = 1'b1; push_cmd = 8'h01; push_data = rect(10'd1, 10'd2, 10'd3, 10'd4, 16'hBEEF);
        step();
        flush = 1'b0; push = 1'b0;
        chk("t5 count0", 256'(count), 256'(0));
        chk("t5 empty", 256'(empty), 256'(1'b1));
        chk("t5 overflow_sticky", 256'(overflow), 256'(1'b1));
        chk("t5 bad_sticky", 256'(bad_cmd), 256'(1'b1));
        chk("t5 still_wait", 256'(dbg_state), 256'(ST_WAIT));
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t5 idle", 256'(dbg_state), 256'(ST_IDLE));
        chk("t5 busy", 256'(busy), 256'(1'b0));
        watch_no_commit("t5 no_more_commit", 10);

        // 6: reset while in S_ISSUE
        d = rect(10'd77, 10'd88, 10'd4, 10'd4, 16'hC0DE);
        do_push(8'h01, d);
        step();
        chk("t6 in_issue", 256'(dbg_state), 256'(ST_ISSUE));
        do_push(8'h01, d);
        do_push(8'h09, d);
        chk("t6 count2", 256'(count), 256'(2));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6 commit", 256'(commit), 256'(1'b0));
        chk("t6 count", 256'(count), 256'(0));
        chk("t6 overflow", 256'(overflow), 256'(1'b0));
        chk("t6 bad_cmd", 256'(bad_cmd), 256'(1'b0));
        chk("t6 state", 256'(dbg_state), 256'(ST_IDLE));
        chk("t6 command", 256'(command), 256'(0));
        exp_q.delete();

        // after reset: flush with push drops the push and leaves overflow clear
        flush = 1'b1; push = 1'b1; push_cmd = 8'h01; push_data = d;
        step();
        flush = 1'b0; push = 1'b0;
        chk("t7 count", 256'(count), 256'(0));
        chk("t7 overflow", 256'(overflow), 256'(1'b0));
        watch_no_commit("t7 no_commit", 3);
        d = rect(10'd3, 10'd4, 10'd5, 10'd6, 16'h0F0F);
        do_push(8'h01, d);
        exp_q.push_back(d);
        serve("t7", 4'd0, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
